mips_cpu_alu: RTL and testbench
===============================

// Module: mips_cpu_alu
// PURPOSE
//  Integer ALU for the multicycle MIPS-I bus CPU, including the architectural HI/LO pair.
//  - Combinational 32-bit result r and zero flag, chosen by a 4-bit control code.
//  - HI/LO written on clk edges by MULT/DIV/MTHI/MTLO ops.
//  - Sits in mips_cpu_bus between register-file read ports and writeback/address logic.
// PARAMETERS
//  none
// PORTS
//  clk       in   1   clock; single clock domain, rising edge
//  reset     in   1   synchronous, active-low reset (sampled on posedge clk)
//  control   in   4   ALU function select (see BEHAVIOUR)
//  a         in   32  operand A (rs)
//  b         in   32  operand B (rt or sign/zero-extended immediate)
//  sa        in   5   shift amount for immediate-shift ops
//  hilo_op   in   3   HI/LO operation; 0 = none
//  r         out  32  combinational result
//  zero      out  1   1 when r == 0 (combinational)
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  control (combinational r; no latency):
//   0000 AND | 0001 OR | 0010 XOR | 0011 NOR | 0100 ADD a+b mod 2^32, no overflow trap
//   0101 SUB a-b mod 2^32 | 0110 SLT signed, r = {31'b0, a<b} | 0111 SLTU unsigned
//   1000 SLL b<<sa | 1001 SRL b>>sa logical | 1010 SRA b>>>sa arithmetic
//   1011 SLLV b<<a[4:0] | 1100 SRLV | 1101 SRAV, using a[4:0]; a[31:5] ignored
//   1110 LUI r = {b[15:0],16'h0} | 1111 DEFAULT r = 32'h0 (zero=1)
//  hilo_op, applied at posedge clk when reset=1:
//   0 none | 1 MULT signed {hi,lo}=a*b | 2 MULTU unsigned
//   3 DIV signed lo=a/b truncated toward zero, hi=a%b with sign of a | 4 DIVU unsigned
//   5 MTHI hi=a | 6 MTLO lo=a | 7 reserved, treated as none
//  Boundaries:
//   - DIV/DIVU with b==0: hi and lo unchanged.
//   - DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
//   - Shifts by 0 pass b through.
//   - Shift amounts of 31 are valid.
//   - ADD/SUB wrap silently.
//  Reset: reset==0 at posedge -> hi=0, lo=0. Reset overrides any hilo_op in the same cycle.
//   r and zero are unaffected by reset; they always follow the inputs.
//  hi/lo outputs reflect the registered values only.
//   A new product/quotient becomes visible the cycle after the issuing edge.
// CONFIGURATION
//  MIPS_ALU_DIV_EN
//   - defined: hilo_op 3/4 perform DIV/DIVU as specified above.
//   - undefined: no divider logic is built; hilo_op 3/4 behave as none (hi/lo hold).
//     MULT/MTHI/MTLO are unaffected.
// STRUCTURE
//  - Shared package mips_cpu_pkg holds:
//    - enum typeALUOp: all 16 control codes; ALU_ADD=4'b0100, ALU_DEFAULT=4'b1111.
//    - enum for hilo_op codes.
//    - opcode/fncode enums used by mips_cpu_bus.
//  - Natural sub-module: mips_cpu_alu_muldiv. It owns HI/LO, the multiplier and the ifdef'd divider.
//  - Top level: combinational case on control, plus the zero compare.
// TESTING
//  1. ADD a=0xFFFFFFFF, b=1 -> r=0, zero=1.
//     SUB a=5, b=7 -> r=0xFFFFFFFE, zero=0.
//  2. SLT a=0xFFFFFFFF, b=1 -> r=1; SLTU with the same operands -> r=0.
//     SRA b=0x80000000, sa=31 -> r=0xFFFFFFFF.
//     SRLV b=0x80000000, a=0x21 (uses 1) -> r=0x40000000.
//  3. MULT a=0xFFFFFFFE (-2), b=3, one edge -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//     MULTU with the same operands -> hi=2, lo=0xFFFFFFFA.
//  4. With MIPS_ALU_DIV_EN:
//     - DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     - Then DIVU b=0 -> hi/lo unchanged.
//     Without the macro, DIV leaves hi/lo at their prior values.
//  5. MTHI a=0x1234, then MTLO a=0x5678 -> hi=0x1234, lo=0x5678.
//     Then reset=0 with hilo_op=MULT on the same edge -> hi=lo=0.
//  6. control=1111 with any a/b -> r=0, zero=1.
//     LUI b=0x0000ABCD -> r=0xABCD0000.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types for the multicycle MIPS-I bus CPU:
// ALU control codes, HI/LO op codes, opcode/fncode enums.
package mips_cpu_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_XOR     = 4'b0010,
    ALU_NOR     = 4'b0011,
    ALU_ADD     = 4'b0100,
    ALU_SUB     = 4'b0101,
    ALU_SLT     = 4'b0110,
    ALU_SLTU    = 4'b0111,
    ALU_SLL     = 4'b1000,
    ALU_SRL     = 4'b1001,
    ALU_SRA     = 4'b1010,
    ALU_SLLV    = 4'b1011,
    ALU_SRLV    = 4'b1100,
    ALU_SRAV    = 4'b1101,
    ALU_LUI     = 4'b1110,
    ALU_DEFAULT = 4'b1111
  } typeALUOp;

  typedef enum logic [2:0] {
    HL_NONE  = 3'd0,
    HL_MULT  = 3'd1,
    HL_MULTU = 3'd2,
    HL_DIV   = 3'd3,
    HL_DIVU  = 3'd4,
    HL_MTHI  = 3'd5,
    HL_MTLO  = 3'd6,
    HL_RSVD  = 3'd7
  } hilo_op_t;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_REGIMM  = 6'h01,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_BLEZ    = 6'h06,
    OP_BGTZ    = 6'h07,
    OP_ADDIU   = 6'h09,
    OP_SLTI    = 6'h0A,
    OP_SLTIU   = 6'h0B,
    OP_ANDI    = 6'h0C,
    OP_ORI     = 6'h0D,
    OP_XORI    = 6'h0E,
    OP_LUI     = 6'h0F,
    OP_LB      = 6'h20,
    OP_LH      = 6'h21,
    OP_LWL     = 6'h22,
    OP_LW      = 6'h23,
    OP_LBU     = 6'h24,
    OP_LHU     = 6'h25,
    OP_LWR     = 6'h26,
    OP_SB      = 6'h28,
    OP_SH      = 6'h29,
    OP_SW      = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL   = 6'h00,
    FN_SRL   = 6'h02,
    FN_SRA   = 6'h03,
    FN_SLLV  = 6'h04,
    FN_SRLV  = 6'h06,
    FN_SRAV  = 6'h07,
    FN_JR    = 6'h08,
    FN_JALR  = 6'h09,
    FN_MFHI  = 6'h10,
    FN_MTHI  = 6'h11,
    FN_MFLO  = 6'h12,
    FN_MTLO  = 6'h13,
    FN_MULT  = 6'h18,
    FN_MULTU = 6'h19,
    FN_DIV   = 6'h1A,
    FN_DIVU  = 6'h1B,
    FN_ADDU  = 6'h21,
    FN_SUBU  = 6'h23,
    FN_AND   = 6'h24,
    FN_OR    = 6'h25,
    FN_XOR   = 6'h26,
    FN_NOR   = 6'h27,
    FN_SLT   = 6'h2A,
    FN_SLTU  = 6'h2B
  } fncode_t;

endpackage

// File: rtl/mips_cpu_alu_if.sv
// ALU bus: master drives control/a/b/sa/hilo_op,
// slave (the ALU) returns r/zero/hi/lo.
interface mips_cpu_alu_if;
  import mips_cpu_pkg::*;

  logic [3:0]  control;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  sa;
  logic [2:0]  hilo_op;
  logic [31:0] r;
  logic        zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output control, a, b, sa, hilo_op,
    input  r, zero, hi, lo
  );

  modport slave (
    input  control, a, b, sa, hilo_op,
    output r, zero, hi, lo
  );
endinterface

// File: rtl/mips_cpu_alu_muldiv.sv
// HI/LO owner: multiplier, optional divider (MIPS_ALU_DIV_EN).
// Ports: clk, reset (sync, active-low), hilo_op, a, b -> hi, lo.
module mips_cpu_alu_muldiv
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  hilo_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  hilo_op_t    op;
  logic        msgn;
  logic [63:0] ma;
  logic [63:0] mb;
  logic [63:0] prod;
  logic [31:0] hi_d, hi_q;
  logic [31:0] lo_d, lo_q;

  assign op   = hilo_op_t'(hilo_op);
  assign msgn = (op == HL_MULT);
  // One 64x64 multiplier; sign-extension selects MULT vs MULTU.
  assign ma   = {{32{msgn & a[31]}}, a};
  assign mb   = {{32{msgn & b[31]}}, b};
  assign prod = ma * mb;

`ifdef MIPS_ALU_DIV_EN
  logic        dsgn;
  logic [31:0] ua, ub, ub_nz;
  logic [31:0] uq, ur;
  logic [31:0] quo, rem;

  // Signed divide via magnitudes, so INT_MIN/-1 needs no
  // special case and the one unsigned divider is shared.
  assign dsgn  = (op == HL_DIV);
  assign ua    = (dsgn & a[31]) ? 32'd0 - a : a;
  assign ub    = (dsgn & b[31]) ? 32'd0 - b : b;
  assign ub_nz = (ub == 32'd0) ? 32'd1 : ub;
  assign uq    = ua / ub_nz;
  assign ur    = ua % ub_nz;
  assign quo   = (dsgn & (a[31] ^ b[31])) ? 32'd0 - uq : uq;
  assign rem   = (dsgn & a[31]) ? 32'd0 - ur : ur;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    unique case (op)
      HL_MULT, HL_MULTU: {hi_d, lo_d} = prod;
`ifdef MIPS_ALU_DIV_EN
      HL_DIV, HL_DIVU: begin
        if (b != 32'd0) begin
          hi_d = rem;
          lo_d = quo;
        end
      end
`endif
      HL_MTHI: hi_d = a;
      HL_MTLO: lo_d = a;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/mips_cpu_alu.sv
// MIPS-I integer ALU: combinational r/zero plus HI/LO pair.
// Ports: clk, reset (sync, active-low), bus (slave). Option: MIPS_ALU_DIV_EN.
module mips_cpu_alu
  import mips_cpu_pkg::*;
(
  input logic           clk,
  input logic           reset,
  mips_cpu_alu_if.slave bus
);

  logic [31:0] a, b, r;
  logic [4:0]  sa, va;

  assign a  = bus.a;
  assign b  = bus.b;
  assign sa = bus.sa;
  assign va = bus.a[4:0];

  always_comb begin
    r = 32'd0;
    unique case (typeALUOp'(bus.control))
      ALU_AND:     r = a & b;
      ALU_OR:      r = a | b;
      ALU_XOR:     r = a ^ b;
      ALU_NOR:     r = ~(a | b);
      ALU_ADD:     r = a + b;
      ALU_SUB:     r = a - b;
      ALU_SLT:     r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:    r = {31'd0, a < b};
      ALU_SLL:     r = b << sa;
      ALU_SRL:     r = b >> sa;
      ALU_SRA:     r = $unsigned($signed(b) >>> sa);
      ALU_SLLV:    r = b << va;
      ALU_SRLV:    r = b >> va;
      ALU_SRAV:    r = $unsigned($signed(b) >>> va);
      ALU_LUI:     r = {b[15:0], 16'h0000};
      ALU_DEFAULT: r = 32'd0;
      default:     r = 32'd0;
    endcase
  end

  assign bus.r    = r;
  assign bus.zero = (r == 32'd0);

  mips_cpu_alu_muldiv u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .hilo_op (bus.hilo_op),
    .a       (bus.a),
    .b       (bus.b),
    .hi      (bus.hi),
    .lo      (bus.lo)
  );

endmodule

// File: tb/tb_mips_cpu_alu.sv
// Directed self-checking bench for mips_cpu_alu.
// Covers ALU ops, HI/LO ops, boundaries and reset.
module tb_mips_cpu_alu;
  import mips_cpu_pkg::*;

  logic clk;
  logic reset;
  int   n_tot;
  int   n_bad;

  mips_cpu_alu_if bus ();

  mips_cpu_alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
    end
  endtask

  task automatic alu(input logic [3:0] c,
                     input logic [31:0] ia,
                     input logic [31:0] ib,
                     input logic [4:0] isa);
    bus.control = c;
    bus.a       = ia;
    bus.b       = ib;
    bus.sa      = isa;
    #1;
  endtask

  task automatic hl(input logic [2:0] op,
                    input logic [31:0] ia,
                    input logic [31:0] ib);
    @(negedge clk);
    bus.hilo_op = op;
    bus.a       = ia;
    bus.b       = ib;
    @(posedge clk);
    #1;
    bus.hilo_op = 3'd0;
  endtask

  initial begin
    n_tot = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.control = 4'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.sa = 5'd0;
    bus.hilo_op = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    alu(4'b0100, 32'hFFFFFFFF, 32'h1, 5'd0);
    chk("add_r", bus.r, 32'h0);
    chk("add_z", {31'd0, bus.zero}, 32'h1);
    alu(4'b0101, 32'h5, 32'h7, 5'd0);
    chk("sub_r", bus.r, 32'hFFFFFFFE);
    chk("sub_z", {31'd0, bus.zero}, 32'h0);
    alu(4'b0000, 32'hF0F0_1234, 32'hFF00_FF00, 5'd0);
    chk("and", bus.r, 32'hF000_1200);
    alu(4'b0001, 32'hF0F0_1234, 32'hFF00_FF00, 5'd0);
    chk("or", bus.r, 32'hFFF0_FF34);
    alu(4'b0010, 32'hF0F0_1234, 32'hFF00_FF00, 5'd0);
    chk("xor", bus.r, 32'h0FF0_ED34);
    alu(4'b0011, 32'hF0F0_1234, 32'hFF00_FF00, 5'd0);
    chk("nor", bus.r, 32'h000F_00CB);
    alu(4'b0110, 32'hFFFFFFFF, 32'h1, 5'd0);
    chk("slt", bus.r, 32'h1);
    alu(4'b0111, 32'hFFFFFFFF, 32'h1, 5'd0);
    chk("sltu", bus.r, 32'h0);
    alu(4'b1010, 32'h0, 32'h80000000, 5'd31);
    chk("sra31", bus.r, 32'hFFFFFFFF);
    alu(4'b1000, 32'h0, 32'h0000_0003, 5'd31);
    chk("sll31", bus.r, 32'h8000_0000);
    alu(4'b1001, 32'h0, 32'h8000_0000, 5'd4);
    chk("srl4", bus.r, 32'h0800_0000);
    alu(4'b1001, 32'h0, 32'hDEAD_BEEF, 5'd0);
    chk("srl0", bus.r, 32'hDEAD_BEEF);
    alu(4'b1100, 32'h21, 32'h80000000, 5'd7);
    chk("srlv", bus.r, 32'h40000000);
    alu(4'b1011, 32'hFFFF_FFE4, 32'h0000_0001, 5'd0);
    chk("sllv", bus.r, 32'h0000_0010);
    alu(4'b1101, 32'h0000_0008, 32'h8000_0000, 5'd0);
    chk("srav", bus.r, 32'hFF80_0000);
    alu(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
    chk("def_r", bus.r, 32'h0);
    chk("def_z", {31'd0, bus.zero}, 32'h1);
    alu(4'b1110, 32'h0, 32'h0000ABCD, 5'd0);
    chk("lui", bus.r, 32'hABCD0000);

    hl(3'd1, 32'hFFFFFFFE, 32'h3);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFFA);
    hl(3'd2, 32'hFFFFFFFE, 32'h3);
    chk("multu_hi", bus.hi, 32'h2);
    chk("multu_lo", bus.lo, 32'hFFFFFFFA);
    hl(3'd7, 32'h1111_1111, 32'h2222_2222);
    chk("rsvd_hi", bus.hi, 32'h2);
    chk("rsvd_lo", bus.lo, 32'hFFFFFFFA);

`ifdef MIPS_ALU_DIV_EN
    hl(3'd3, 32'hFFFFFFF9, 32'h2);
    chk("div_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_hi", bus.hi, 32'hFFFFFFFF);
    hl(3'd4, 32'h1234, 32'h0);
    chk("divu0_lo", bus.lo, 32'hFFFFFFFD);
    chk("divu0_hi", bus.hi, 32'hFFFFFFFF);
    hl(3'd4, 32'hFFFFFFF9, 32'h2);
    chk("divu_lo", bus.lo, 32'h7FFFFFFC);
    chk("divu_hi", bus.hi, 32'h1);
    hl(3'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("divmin_lo", bus.lo, 32'h80000000);
    chk("divmin_hi", bus.hi, 32'h0);
`else
    hl(3'd3, 32'hFFFFFFF9, 32'h2);
    chk("nodiv_lo", bus.lo, 32'hFFFFFFFA);
    chk("nodiv_hi", bus.hi, 32'h2);
    hl(3'd4, 32'hFFFFFFF9, 32'h2);
    chk("nodivu_lo", bus.lo, 32'hFFFFFFFA);
    chk("nodivu_hi", bus.hi, 32'h2);
`endif

    hl(3'd5, 32'h1234, 32'h0);
    hl(3'd6, 32'h5678, 32'h0);
    chk("mthi", bus.hi, 32'h1234);
    chk("mtlo", bus.lo, 32'h5678);

    @(negedge clk);
    reset = 1'b0;
    bus.hilo_op = 3'd1;
    bus.a = 32'h7;
    bus.b = 32'h9;
    @(posedge clk);
    #1;
    chk("rstov_hi", bus.hi, 32'h0);
    chk("rstov_lo", bus.lo, 32'h0);
    bus.control = 4'b0100;
    #1;
    chk("rst_comb", bus.r, 32'h10);
    @(negedge clk);
    reset = 1'b1;
    bus.hilo_op = 3'd0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
